// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous line; both stages reset to 1.
module sync_2ff (
  input  logic i_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// Serial receiver: 8N1 with optional even parity, emitting byte write strobes and error strobes.
module rx_uart
  import uart_pkg::*;
#(
  parameter int unsigned clkFreq   = 25_000_000,
  parameter int unsigned baudRate  = 115200,
  parameter logic        if_parity = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      rst,
  input  logic                      i_uart_rx,
  output logic                      o_wr,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_frame_err,
  output logic                      o_parity_err
);

  localparam int unsigned CNT_W        = 16;
  localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(clkFreq, baudRate);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic rx_s, rx_prev;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .rst   (rst),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  rx_state_t                 state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic [BIT_W-1:0]          bit_cnt, bit_n;
  logic                      par_bit, par_n;
  logic                      stop_q, stop_n;
  logic                      done_q, done_n;
  logic                      wr_n, ferr_n, perr_n;
  logic                      par_bad;

  assign par_bad = if_parity & (^{shreg, par_bit});

  // Next state, datapath and strobes; strobes follow the stop sample by one cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    shreg_n = shreg;
    bit_n   = bit_cnt;
    par_n   = par_bit;
    stop_n  = stop_q;
    done_n  = 1'b0;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    data_n  = o_data;

    if (done_q) begin
      if (!stop_q) begin
        ferr_n = 1'b1;
      end else if (par_bad) begin
        perr_n = 1'b1;
      end else begin
        wr_n   = 1'b1;
        data_n = shreg;
      end
    end

    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        // A start needs a visible high-to-low transition, which also covers break recovery.
        if (rx_prev && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_n   = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) state_n = if_parity ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          stop_n  = rx_s;
          done_n  = 1'b1;
          state_n = RX_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      stop_q       <= 1'b1;
      done_q       <= 1'b0;
      rx_prev      <= 1'b1;
      o_wr         <= 1'b0;
      o_data       <= '0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_n;
      par_bit      <= par_n;
      stop_q       <= stop_n;
      done_q       <= done_n;
      rx_prev      <= rx_s;
      o_wr         <= wr_n;
      o_data       <= data_n;
      o_frame_err  <= ferr_n;
      o_parity_err <= perr_n;
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: one DUT without parity, one with even parity.
module tb_rx_uart;

  localparam int CPB     = 217;
  localparam int LATENCY = 2065;  // pin edge (driven at negedge) to o_wr sample, in cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       wr_a, ferr_a, perr_a, wr_b, ferr_b, perr_b;
  logic [7:0] data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  int   wr_a_hi = 0, ferr_a_hi = 0, perr_a_hi = 0;
  int   wr_b_hi = 0, ferr_b_hi = 0, perr_b_hi = 0;
  logic wr_a_q = 1'b0;
  int   wr_cyc_q[$];
  logic [7:0] wr_data_q[$];

  rx_uart u_dut_a (
    .i_clk        (clk),
    .rst          (rst),
    .i_uart_rx    (rx_a),
    .o_wr         (wr_a),
    .o_data       (data_a),
    .o_frame_err  (ferr_a),
    .o_parity_err (perr_a)
  );

  rx_uart #(.if_parity(1'b1)) u_dut_b (
    .i_clk        (clk),
    .rst          (rst),
    .i_uart_rx    (rx_b),
    .o_wr         (wr_b),
    .o_data       (data_b),
    .o_frame_err  (ferr_b),
    .o_parity_err (perr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts high cycles, logs each o_wr rising edge with its data.
  always @(negedge clk) begin
    if (wr_a) begin
      wr_a_hi++;
      if (!wr_a_q) begin
        wr_cyc_q.push_back(cyc);
        wr_data_q.push_back(data_a);
      end
    end
    wr_a_q = wr_a;
    if (ferr_a) ferr_a_hi++;
    if (perr_a) perr_a_hi++;
    if (wr_b)   wr_b_hi++;
    if (ferr_b) ferr_b_hi++;
    if (perr_b) perr_b_hi++;
  end

  task automatic drive(input bit sel, input logic v, input int cycles);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Caller is aligned to a negedge; the start edge is driven immediately.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input bit par, input bit stop, input int period);
    start_cyc = cyc;
    drive(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(sel, d[i], period);
    if (par_en) drive(sel, par, period);
    drive(sel, stop, period);
  endtask

  task automatic test_reset();
    int base_wr;
    rst = 1'b1;
    send_frame(0, 8'h41, 0, 0, 1, CPB);
    repeat (10) @(negedge clk);
    n_checks++;
    if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_a); end
    n_checks++;
    if (wr_a_hi + ferr_a_hi + perr_a_hi !== 0) begin
      n_fail++; $display("FAIL reset_strobes: got %0d strobe cycles expected 0", wr_a_hi + ferr_a_hi + perr_a_hi);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    base_wr = wr_a_hi;
    wr_cyc_q.delete();
    wr_data_q.delete();
    send_frame(0, 8'h41, 0, 0, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_a_hi - base_wr !== 1) begin n_fail++; $display("FAIL reset_first_wr: got %0d wr cycles expected 1", wr_a_hi - base_wr); end
    n_checks++;
    if (data_a !== 8'h41) begin n_fail++; $display("FAIL reset_first_data: got %h expected 41", data_a); end
    n_checks++;
    if (wr_cyc_q.size() !== 1) begin
      n_fail++; $display("FAIL reset_latency: got %0d pulses expected 1", wr_cyc_q.size());
    end else if (wr_cyc_q[0] - start_cyc !== LATENCY) begin
      n_fail++; $display("FAIL reset_latency: got %0d cycles expected %0d", wr_cyc_q[0] - start_cyc, LATENCY);
    end
  endtask

  task automatic test_directions();
    int base_wr;
    logic [7:0] exp;
    base_wr = wr_a_hi;
    wr_cyc_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 4; i++) send_frame(0, 8'h41 + 8'(i), 0, 0, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_a_hi - base_wr !== 4) begin n_fail++; $display("FAIL dir_wr_cycles: got %0d expected 4", wr_a_hi - base_wr); end
    n_checks++;
    if (wr_data_q.size() !== 4) begin
      n_fail++; $display("FAIL dir_pulses: got %0d expected 4", wr_data_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 8'h41 + 8'(i);
        n_checks++;
        if (wr_data_q[i] !== exp) begin n_fail++; $display("FAIL dir_data%0d: got %h expected %h", i, wr_data_q[i], exp); end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] < 10*CPB - 2 || wr_cyc_q[i] - wr_cyc_q[i-1] > 10*CPB + 2) begin
          n_fail++; $display("FAIL dir_spacing%0d: got %0d expected %0d+-2", i, wr_cyc_q[i] - wr_cyc_q[i-1], 10*CPB);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int base;
    base = wr_a_hi + ferr_a_hi;
    drive(0, 1'b0, 50);
    drive(0, 1'b1, 400);
    n_checks++;
    if (wr_a_hi + ferr_a_hi - base !== 0) begin
      n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", wr_a_hi + ferr_a_hi - base);
    end
    n_checks++;
    if (data_a !== 8'h44) begin n_fail++; $display("FAIL glitch_data: got %h expected 44", data_a); end
  endtask

  task automatic test_framing();
    int base_wr, base_fe;
    base_wr = wr_a_hi;
    base_fe = ferr_a_hi;
    send_frame(0, 8'h55, 0, 0, 0, CPB);
    drive(0, 1'b0, 20*CPB);
    n_checks++;
    if (ferr_a_hi - base_fe !== 1) begin n_fail++; $display("FAIL frame_err: got %0d cycles expected 1", ferr_a_hi - base_fe); end
    n_checks++;
    if (wr_a_hi - base_wr !== 0) begin n_fail++; $display("FAIL frame_no_wr: got %0d expected 0", wr_a_hi - base_wr); end
    n_checks++;
    if (data_a !== 8'h44) begin n_fail++; $display("FAIL frame_data: got %h expected 44", data_a); end
    drive(0, 1'b1, 100);
    send_frame(0, 8'h42, 0, 0, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (ferr_a_hi - base_fe !== 1) begin n_fail++; $display("FAIL frame_err_after: got %0d expected 1", ferr_a_hi - base_fe); end
    n_checks++;
    if (wr_a_hi - base_wr !== 1 || data_a !== 8'h42) begin
      n_fail++; $display("FAIL frame_recover: got wr %0d data %h expected wr 1 data 42", wr_a_hi - base_wr, data_a);
    end
  endtask

  task automatic test_parity();
    send_frame(1, 8'h03, 1, 0, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_b_hi !== 1 || data_b !== 8'h03) begin
      n_fail++; $display("FAIL par_good: got wr %0d data %h expected wr 1 data 03", wr_b_hi, data_b);
    end
    send_frame(1, 8'h03, 1, 1, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (perr_b_hi !== 1) begin n_fail++; $display("FAIL par_err: got %0d cycles expected 1", perr_b_hi); end
    n_checks++;
    if (wr_b_hi !== 1 || data_b !== 8'h03) begin
      n_fail++; $display("FAIL par_bad_no_wr: got wr %0d data %h expected wr 1 data 03", wr_b_hi, data_b);
    end
    send_frame(1, 8'h07, 1, 1, 1, CPB);
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_b_hi !== 2 || data_b !== 8'h07 || perr_b_hi !== 1) begin
      n_fail++; $display("FAIL par_odd_weight: got wr %0d perr %0d data %h expected wr 2 perr 1 data 07", wr_b_hi, perr_b_hi, data_b);
    end
    n_checks++;
    if (ferr_b_hi !== 0) begin n_fail++; $display("FAIL par_ferr: got %0d expected 0", ferr_b_hi); end
  endtask

  task automatic test_baud_skew();
    int base_wr, base_fe;
    base_wr = wr_a_hi;
    base_fe = ferr_a_hi;
    send_frame(0, 8'hA5, 0, 0, 1, 224);
    repeat (100) @(negedge clk);
    n_checks++;
    if (wr_a_hi - base_wr !== 1 || data_a !== 8'hA5) begin
      n_fail++; $display("FAIL skew_slow: got wr %0d data %h expected wr 1 data a5", wr_a_hi - base_wr, data_a);
    end
    send_frame(0, 8'hA5, 0, 0, 1, 210);
    repeat (100) @(negedge clk);
    n_checks++;
    if (wr_a_hi - base_wr !== 2 || data_a !== 8'hA5) begin
      n_fail++; $display("FAIL skew_fast: got wr %0d data %h expected wr 2 data a5", wr_a_hi - base_wr, data_a);
    end
    n_checks++;
    if (ferr_a_hi - base_fe !== 0) begin n_fail++; $display("FAIL skew_ferr: got %0d expected 0", ferr_a_hi - base_fe); end
    n_checks++;
    if (perr_a_hi !== 0) begin n_fail++; $display("FAIL no_parity_tied: got %0d expected 0", perr_a_hi); end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    test_reset();
    test_directions();
    test_glitch();
    test_framing();
    test_parity();
    test_baud_skew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
